// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the data-memory burst initiator and the memory it drives.
package mem_ctrl_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RD_TAIL,
        ST_WR,
        ST_WR_TAIL
    } state_e;

    // A burst is legal only if its last word A + len stays below the limit.
    // The sum is one bit wider than the address so a base near 16'hFFFF
    // cannot wrap around into the legal range.
    function automatic logic burst_out_of_range(
        input logic [ADDR_W-1:0] base,
        input logic [LEN_W-1:0]  len,
        input logic [ADDR_W:0]   limit
    );
        logic [ADDR_W:0] last_word;
        last_word = {1'b0, base} + {{(ADDR_W + 1 - LEN_W){1'b0}}, len};
        return last_word >= limit;
    endfunction

endpackage

// File: rtl/mem_burst_master.sv
// Burst initiator for the 16-bit synchronous data memory port. Accepts
// 1..16 word read/write bursts over valid/ready, sequences the memory port
// one access per cycle, streams write beats in and read words out, and
// signals completion (done) or a rejected out-of-range request (err).
module mem_burst_master
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_LIMIT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wvalid,
    output logic              wready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              err,
    output logic              mem_wenable,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam int                  LIMIT_W  = ADDR_W + 1;
    localparam logic [LIMIT_W-1:0]  LIMIT    = LIMIT_W'(ADDR_LIMIT);
    localparam logic [ADDR_W-1:0]   ADDR_ONE = ADDR_W'(1);
    localparam logic [LEN_W-1:0]    BEAT_ONE = LEN_W'(1);

    state_e              state_q;
    logic [ADDR_W-1:0]   base_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    beat_q;
    logic                mem_wenable_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_data_in_q;
    logic                rvalid_q;
    logic                done_q;
    logic                err_q;

    logic                range_err_d;
    logic                last_beat;
    logic [LEN_W-1:0]    beat_d;
    logic [ADDR_W-1:0]   rd_addr_d;
    logic [ADDR_W-1:0]   wr_addr_d;

    // Next-value helpers: range check of the incoming request, beat bookkeeping
    // and the two address sources (sequential read issue, base+beat for writes).
    assign range_err_d = burst_out_of_range(req_addr, req_len, LIMIT);
    assign last_beat   = (beat_q == len_q);
    assign beat_d      = beat_q + BEAT_ONE;
    assign rd_addr_d   = mem_addr_q + ADDR_ONE;
    assign wr_addr_d   = base_q + {{(ADDR_W - LEN_W){1'b0}}, beat_q};

    // Burst sequencer: state, beat counter and every registered port output.
    // NOTE: all state here is written with <= so every register samples the
    // pre-edge values of its neighbours; blocking writes would make the result
    // depend on statement order.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled synchronously inside the clocked block, so it
        // only takes effect on an edge; a write already on the port at that
        // edge still reaches the memory.
        if (rst) begin
            state_q       <= ST_IDLE;
            base_q        <= '0;
            len_q         <= '0;
            beat_q        <= '0;
            mem_wenable_q <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_in_q <= '0;
            rvalid_q      <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            // Pulses and the write strobe default low; the memory's registered
            // read makes a word valid the cycle after an RD issue.
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            mem_wenable_q <= 1'b0;
            rvalid_q      <= (state_q == ST_RD);

            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (range_err_d) begin
                            err_q <= 1'b1;
                        end else begin
                            base_q <= req_addr;
                            len_q  <= req_len;
                            beat_q <= '0;
                            if (req_we) begin
                                state_q <= ST_WR;
                            end else begin
                                state_q    <= ST_RD;
                                mem_addr_q <= req_addr;
                            end
                        end
                    end
                end

                ST_RD: begin
                    if (last_beat) begin
                        state_q <= ST_RD_TAIL;
                    end else begin
                        mem_addr_q <= rd_addr_d;
                        beat_q     <= beat_d;
                    end
                end

                ST_RD_TAIL: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b1;
                end

                ST_WR: begin
                    if (wvalid) begin
                        mem_wenable_q <= 1'b1;
                        mem_addr_q    <= wr_addr_d;
                        mem_data_in_q <= wdata;
                        if (last_beat) begin
                            state_q <= ST_WR_TAIL;
                        end else begin
                            beat_q <= beat_d;
                        end
                    end
                end

                ST_WR_TAIL: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b1;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake decodes and gated read data.
    assign req_ready   = (state_q == ST_IDLE);
    assign wready      = (state_q == ST_WR);
    assign rdata       = rvalid_q ? mem_data_out : '0;

    assign rvalid      = rvalid_q;
    assign done        = done_q;
    assign err         = err_q;
    assign mem_wenable = mem_wenable_q;
    assign mem_addr    = mem_addr_q;
    assign mem_data_in = mem_data_in_q;

endmodule
